// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: holds a small program buffer served combinationally on
// the CPU instruction port, sequences CPU reset / clock-enable, counts run
// cycles and compares register_v0 against a latched expected value.
module cpu_test_sequencer #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] ADDR_BASE = 32'hBFC00000,
    parameter int          TIMEOUT   = 10000,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] expected,
    input  logic [CNT_W-1:0]  check_cycles,
    output logic              cpu_reset,
    output logic              cpu_clk_enable,
    input  logic [31:0]       instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    input  logic              active,
    input  logic [DATA_W-1:0] register_v0,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              addr_err,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    DEPTH_C   = PW'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
    logic [CNT_W-1:0]  chk_q, chk_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic              addr_err_q, addr_err_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              cpu_clk_enable_q, cpu_clk_enable_d;
    logic              load_ready_q, load_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_we_s;
    logic              fetch_ok_s;
    logic [31:0]       offset_s;
    logic [31:0]       idx_s;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Fetch decode: word index relative to ADDR_BASE, NOP for anything not loaded
    always_comb begin
        offset_s = instr_address - ADDR_BASE;
        idx_s    = offset_s >> 2;
        if ((instr_address[1:0] == 2'b00) && (idx_s < {{(32-PW){1'b0}}, wr_ptr_q})) begin
            fetch_ok_s     = 1'b1;
            instr_readdata = mem_q[idx_s[AW-1:0]];
        end else begin
            fetch_ok_s     = 1'b0;
            instr_readdata = {DATA_W{1'b0}};
        end
    end

    // Program buffer write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= load_data;
        end
    end

    // Sequencer next state, status flags and next values of registered outputs
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        exp_d      = exp_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        mem_we_s   = 1'b0;
        cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if ((state_q == S_RUN) && !fetch_ok_s) begin
            addr_err_d = 1'b1;
        end else begin
            addr_err_d = addr_err_q;
        end
        case (state_q)
            S_IDLE: begin
                if (load_valid && load_ready_q) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    mem_we_s = 1'b0;
                    wr_ptr_d = wr_ptr_q;
                end
                // start sees the buffer including a word written in the same cycle
                if (start && (wr_ptr_d != {PW{1'b0}})) begin
                    state_d    = S_RST;
                    exp_d      = expected;
                    chk_d      = check_cycles;
                    cnt_d      = {CNT_W{1'b0}};
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    timeout_d  = 1'b0;
                    addr_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RST: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc_s;
                if ((chk_q != {CNT_W{1'b0}}) && (cnt_inc_s == chk_q)) begin
                    state_d = S_CHECK;
                end else if ((chk_q == {CNT_W{1'b0}}) && !active && (cnt_q != {CNT_W{1'b0}})) begin
                    state_d = S_CHECK;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_CHECK: begin
                pass_d  = (register_v0 == exp_q);
                fail_d  = (register_v0 != exp_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                // clear has priority; start is never accepted here
                if (clear) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = {PW{1'b0}};
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cpu_reset_d      = (state_d == S_RST);
        cpu_clk_enable_d = (state_d == S_RUN);
        busy_d           = (state_d == S_RST) || (state_d == S_RUN) || (state_d == S_CHECK);
        done_d           = (state_d == S_DONE);
        load_ready_d     = (state_d == S_IDLE) && (wr_ptr_d < DEPTH_C);
    end

    // State, latched values and registered outputs; reset holds the CPU in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            wr_ptr_q         <= {PW{1'b0}};
            cnt_q            <= {CNT_W{1'b0}};
            chk_q            <= {CNT_W{1'b0}};
            exp_q            <= {DATA_W{1'b0}};
            pass_q           <= 1'b0;
            fail_q           <= 1'b0;
            timeout_q        <= 1'b0;
            addr_err_q       <= 1'b0;
            cpu_reset_q      <= 1'b1;
            cpu_clk_enable_q <= 1'b0;
            load_ready_q     <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            cnt_q            <= cnt_d;
            chk_q            <= chk_d;
            exp_q            <= exp_d;
            pass_q           <= pass_d;
            fail_q           <= fail_d;
            timeout_q        <= timeout_d;
            addr_err_q       <= addr_err_d;
            cpu_reset_q      <= cpu_reset_d;
            cpu_clk_enable_q <= cpu_clk_enable_d;
            load_ready_q     <= load_ready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign load_ready     = load_ready_q;
    assign cpu_reset      = cpu_reset_q;
    assign cpu_clk_enable = cpu_clk_enable_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign timeout        = timeout_q;
    assign addr_err       = addr_err_q;
    assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Self-checking bench for cpu_test_sequencer: random programs, check windows,
// active-drop points and bad fetch addresses against a transaction-level model.
module tb_cpu_test_sequencer;
    localparam int          DATA_W  = 32;
    localparam int          DEPTH   = 16;
    localparam int          CNT_W   = 16;
    localparam int          TIMEOUT = 64;
    localparam logic [31:0] BASE    = 32'hBFC00000;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              start;
    logic              clear;
    logic [DATA_W-1:0] expected;
    logic [CNT_W-1:0]  check_cycles;
    logic              cpu_reset;
    logic              cpu_clk_enable;
    logic [31:0]       instr_address;
    logic [DATA_W-1:0] instr_readdata;
    logic              active;
    logic [DATA_W-1:0] register_v0;
    logic              busy, done, pass, fail, timeout, addr_err;
    logic [CNT_W-1:0]  cycle_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] words[$];
    bit          addr_err_m;

    always #5 clk = ~clk;

    cpu_test_sequencer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_BASE(BASE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .start(start), .clear(clear), .expected(expected), .check_cycles(check_cycles),
        .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .active(active), .register_v0(register_v0),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .addr_err(addr_err), .cycle_count(cycle_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A fetch is legal if word-aligned and inside the loaded part of the buffer
    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] == 2'b00) && ((off / 4) < 32'(words.size()));
    endfunction

    function automatic logic [31:0] fetch_model(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (addr_ok(a)) return words[off / 4];
        return 32'h0;
    endfunction

    task automatic check_flags_clear(input string tag);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_pass"}, pass, 1'b0);
        check_eq({tag, "_fail"}, fail, 1'b0);
        check_eq({tag, "_timeout"}, timeout, 1'b0);
        check_eq({tag, "_addr_err"}, addr_err, 1'b0);
        check_eq({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // One complete test: load n words, start, run, check, done, clear.
    // k = check_cycles, drop = RUN cycle at which active falls (0 = never),
    // bad_c = RUN cycle that fetches an illegal address (0 = none),
    // comb = start in the same cycle as the last offered word.
    task automatic run_test(input int n, input int k, input bit match, input int drop,
                            input int bad_c, input bit comb);
        logic [31:0] v0, ex;
        int          e;
        bit          to;
        int          sel;
        v0 = $urandom;
        ex = match ? v0 : (v0 ^ (32'h1 << $urandom_range(0, 31)));
        register_v0 = v0;
        active = 1'b1;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            if (comb && (i == n - 1)) begin
                start = 1'b1; expected = ex; check_cycles = CNT_W'(k);
            end
            @(negedge clk);
            check_eq("load_ready", load_ready, (words.size() < DEPTH));
            if (words.size() < DEPTH) words.push_back(load_data);
            tick();
        end
        load_valid = 1'b0;
        if (!comb) begin
            instr_address = BASE + 32'(4 * (words.size() - 1));
            @(negedge clk);
            check_eq("idle_fetch_last", instr_readdata, fetch_model(instr_address));
            check_eq("idle_load_ready", load_ready, (words.size() < DEPTH));
            instr_address = BASE + 32'(4 * words.size());
            #1;
            check_eq("idle_fetch_past_end", instr_readdata, 32'h0);
            tick();
            start = 1'b1; expected = ex; check_cycles = CNT_W'(k);
            tick();
        end
        start = 1'b0; expected = $urandom; check_cycles = CNT_W'($urandom);

        if (k != 0) begin
            e  = (k <= TIMEOUT) ? k : TIMEOUT;
            to = (k > TIMEOUT);
        end else if (drop != 0) begin
            e  = (drop < 2) ? 2 : drop;
            to = 1'b0;
        end else begin
            e  = TIMEOUT;
            to = 1'b1;
        end
        addr_err_m = 1'b0;

        // Reset cycle: bad address here must not count
        instr_address = BASE - 32'd4;
        @(negedge clk);
        check_eq("rst_cpu_reset", cpu_reset, 1'b1);
        check_eq("rst_clk_en", cpu_clk_enable, 1'b0);
        check_eq("rst_busy", busy, 1'b1);
        check_flags_clear("rst");
        tick();

        for (int c = 1; c <= e; c++) begin
            active = ((k != 0) || (drop == 0)) ? 1'b1 : ((c < drop) ? 1'b1 : 1'b0);
            if (c == bad_c) begin
                sel = $urandom_range(0, 2);
                case (sel)
                    0:       instr_address = BASE + 32'(4 * words.size());
                    1:       instr_address = BASE + 32'd2;
                    default: instr_address = BASE - 32'd4;
                endcase
            end else begin
                instr_address = BASE + 32'(4 * $urandom_range(0, words.size() - 1));
            end
            @(negedge clk);
            check_eq("run_clk_en", cpu_clk_enable, 1'b1);
            check_eq("run_cpu_reset", cpu_reset, 1'b0);
            check_eq("run_cycle_count", cycle_count, c - 1);
            check_eq("run_addr_err", addr_err, addr_err_m);
            check_eq("run_fetch", instr_readdata, fetch_model(instr_address));
            if (!addr_ok(instr_address)) addr_err_m = 1'b1;
            tick();
        end
        active = 1'b1;
        instr_address = BASE + 32'd2;
        if (!to) begin
            @(negedge clk);
            check_eq("chk_busy", busy, 1'b1);
            check_eq("chk_clk_en", cpu_clk_enable, 1'b0);
            check_eq("chk_done", done, 1'b0);
            tick();
        end

        @(negedge clk);
        check_eq("done_done", done, 1'b1);
        check_eq("done_pass", pass, (!to && match));
        check_eq("done_fail", fail, (to || !match));
        check_eq("done_timeout", timeout, to);
        check_eq("done_addr_err", addr_err, addr_err_m);
        check_eq("done_cycle_count", cycle_count, e);
        check_eq("done_busy", busy, 1'b0);
        check_eq("done_clk_en", cpu_clk_enable, 1'b0);
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("done_start_ignored_busy", busy, 1'b0);
        check_eq("done_start_ignored_done", done, 1'b1);
        check_eq("done_held_count", cycle_count, e);
        tick();

        clear = 1'b1;
        start = 1'($urandom_range(0, 1));
        tick();
        clear = 1'b0;
        start = 1'b0;
        words.delete();
        instr_address = BASE;
        @(negedge clk);
        check_eq("clear_done", done, 1'b0);
        check_eq("clear_busy", busy, 1'b0);
        check_eq("clear_load_ready", load_ready, 1'b1);
        check_eq("clear_fetch_empty", instr_readdata, 32'h0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; clear = 1'b0;
        expected = '0; check_cycles = '0; instr_address = BASE; active = 1'b1;
        register_v0 = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        check_eq("por_cpu_reset", cpu_reset, 1'b1);
        check_eq("por_clk_en", cpu_clk_enable, 1'b0);
        check_eq("por_load_ready", load_ready, 1'b0);
        check_eq("por_busy", busy, 1'b0);
        check_flags_clear("por");
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_eq("rel_cpu_reset", cpu_reset, 1'b0);
        check_eq("rel_load_ready", load_ready, 1'b1);
        check_eq("rel_fetch_empty", instr_readdata, 32'h0);
        tick();

        // Directed scenarios
        run_test(1, 2, 1'b1, 0, 0, 1'b0);          // pass after two RUN cycles
        run_test(1, 2, 1'b0, 0, 0, 1'b0);          // compare mismatch
        run_test(3, 0, 1'b1, 0, 0, 1'b0);          // active never drops: timeout
        run_test(3, 0, 1'b1, 5, 0, 1'b0);          // active drops at cycle 5
        run_test(3, 0, 1'b0, 5, 3, 1'b0);          // fail plus bad fetch
        run_test(DEPTH + 1, 4, 1'b1, 0, 2, 1'b0);  // overfilled buffer
        run_test(2, 3, 1'b1, 0, 0, 1'b1);          // load and start together
        run_test(1, 100, 1'b1, 0, 0, 1'b0);        // check window beyond timeout
        run_test(2, 0, 1'b1, 1, 0, 1'b0);          // active low from first cycle

        // Reset in the middle of RUN
        load_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_data = $urandom;
            words.push_back(load_data);
            tick();
        end
        load_valid = 1'b0;
        start = 1'b1; expected = '0; check_cycles = 16'd20;
        tick();
        start = 1'b0;
        tick();
        instr_address = BASE - 32'd4;
        tick();
        instr_address = BASE;
        tick();
        @(negedge clk);
        check_eq("mid_pre_count", cycle_count, 2);
        check_eq("mid_pre_addr_err", addr_err, 1'b1);
        check_eq("mid_pre_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("mid_cpu_reset", cpu_reset, 1'b1);
        check_eq("mid_busy", busy, 1'b0);
        check_eq("mid_clk_en", cpu_clk_enable, 1'b0);
        check_eq("mid_load_ready", load_ready, 1'b0);
        check_flags_clear("mid");
        words.delete();
        #2 reset = 1'b1;
        tick();
        @(negedge clk);
        check_eq("mid_rel_cpu_reset", cpu_reset, 1'b0);
        check_eq("mid_rel_fetch", instr_readdata, 32'h0);
        tick();
        start = 1'b1; check_cycles = 16'd3;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("empty_start_busy", busy, 1'b0);
        check_eq("empty_start_cpu_reset", cpu_reset, 1'b0);
        tick();
        @(negedge clk);
        check_eq("empty_start_busy2", busy, 1'b0);
        tick();

        // Randomized scenarios
        for (int t = 0; t < 14; t++) begin
            int n, k, drop, bad_c;
            bit match, comb;
            n     = $urandom_range(1, DEPTH + 1);
            k     = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            drop  = (k != 0) ? 0 : (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40));
            bad_c = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
            match = 1'($urandom_range(0, 1));
            comb  = 1'($urandom_range(0, 1));
            run_test(n, k, match, drop, bad_c, comb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/cpu_test_sequencer.md
# cpu_test_sequencer

Synthesizable, parametrised stimulus-and-check engine for single-instruction and short-program CPU tests on `mips_cpu_harvard`. It holds a small program buffer and serves it combinationally on the instruction port. It sequences CPU reset and clock-enable, counts run cycles, and compares `register_v0` against an expected value. It reports pass, fail or timeout, which replaces per-instruction hand-written stimulus and fixed-cycle asserts.

## Interface
- `DATA_W`, 32, instruction/register width
- `DEPTH`, 16, program buffer words (power of 2, ≥2)
- `ADDR_BASE`, 32'hBFC00000, byte address of buffer word 0
- `TIMEOUT`, 10000, max RUN cycles before timeout
- `CNT_W`, 16, width of cycle counter and `check_cycles`
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `load_valid`  in  1  program word offered
- `load_data`  in  DATA_W  program word
- `load_ready`  out  1  buffer accepts word this cycle
- `start`  in  1  begin test (pulse)
- `clear`  in  1  return from DONE to IDLE, empty buffer
- `expected`  in  DATA_W  expected `register_v0`, sampled on accepted `start`
- `check_cycles`  in  CNT_W  RUN cycles before compare; 0 = wait for `active` low; sampled on accepted `start`
- `cpu_reset`  out  1  active-high reset to CPU
- `cpu_clk_enable`  out  1  CPU clock enable
- `instr_address`  in  32  CPU fetch address
- `instr_readdata`  out  DATA_W  fetched word (combinational)
- `active`  in  1  CPU active
- `register_v0`  in  DATA_W  CPU v0
- `busy`, `done`, `pass`, `fail`, `timeout`, `addr_err`  out  1 each  status
- `cycle_count`  out  CNT_W  RUN cycles elapsed

## Operation
- States: IDLE, RST, RUN, CHECK, DONE.
- IDLE: `load_ready` = (wr_ptr < DEPTH). On `load_valid && load_ready`, write `load_data` to buf[wr_ptr] and increment wr_ptr. When full, `load_ready`=0 and `load_valid` is ignored.
- IDLE + `start` with wr_ptr>0 → RST. Latch `expected` and `check_cycles`, clear all status flags and `cycle_count`. `start` with wr_ptr==0 is ignored. `start` outside IDLE is ignored.
- RST: `cpu_reset`=1, `cpu_clk_enable`=0 for exactly one cycle → RUN.
- RUN: `cpu_reset`=0, `cpu_clk_enable`=1, `cycle_count` increments every cycle.
  - If check_cycles≠0 and `cycle_count` reaches check_cycles → CHECK.
  - If check_cycles==0 and `active`==0 with `cycle_count`≥1 → CHECK.
  - If `cycle_count` reaches TIMEOUT first → DONE with `timeout`=1, `fail`=1.
- CHECK: one cycle with `cpu_clk_enable`=0. `pass` = (`register_v0`==latched expected), `fail` = !`pass`. → DONE.
- DONE: `done`=1, flags held, CPU frozen (`cpu_clk_enable`=0). `clear` → IDLE with wr_ptr=0. `start` in DONE is ignored.
- Fetch: idx = (`instr_address` − ADDR_BASE)>>2.
  - If idx<wr_ptr and `instr_address`[1:0]==0, `instr_readdata`=buf[idx].
  - Otherwise `instr_readdata`=0 (NOP). If the state is RUN, `addr_err` is set sticky; it clears on accepted `start`.
- Address arithmetic is 32-bit unsigned. Addresses below ADDR_BASE wrap to a large idx and are treated as out of range.
- `busy` = state ∈ {RST, RUN, CHECK}.

## Timing
- Reset (reset=0, asynchronous): state IDLE, wr_ptr=0, `cpu_reset`=1, `cpu_clk_enable`=0, `load_ready`=0 while asserted. All status flags, `cycle_count` and latched values are 0. Buffer contents are don't-care.
- After reset release, IDLE drives `cpu_reset`=0 and `load_ready`=1.
- Reset mid-RUN aborts immediately to the reset values above; no partial status survives.
- A word is accepted at the rising edge where `load_valid && load_ready`. It is readable via fetch in the same cycle wr_ptr updates (next cycle).
- `start` accepted at edge N → RST during N+1 → first RUN cycle N+2.
- With check_cycles=K: CHECK at RUN cycle K+1. `done`/`pass`/`fail` are valid from the following cycle and held.
- `start` and `load_valid` asserted in the same IDLE cycle: the word is written and `start` uses the post-write wr_ptr.
- `clear` and `start` in the same DONE cycle: `clear` wins, `start` is dropped.
- `instr_readdata` has zero latency from `instr_address` (combinational).

## Test plan
- Load 32'h24220020 (addiu $2,$1,0x20 path), expected=32'h20, check_cycles=2, start → `cpu_reset` high one cycle, two RUN cycles, `pass`=1, `fail`=0, `cycle_count`=2, `done`=1.
- Same program, expected=32'h21 → `fail`=1, `pass`=0, `timeout`=0.
- TIMEOUT=64, check_cycles=0, `active` held 1 → `timeout`=1 and `fail`=1 at `cycle_count`=64. With `active` dropped at RUN cycle 5 instead → CHECK after cycle 5, and pass/fail follows the compare.
- Offer DEPTH+1 words back-to-back → `load_ready` falls after word DEPTH, the extra word is not stored, and the fetch at ADDR_BASE+4·(DEPTH−1) returns word DEPTH−1.
- During RUN, drive `instr_address`=ADDR_BASE+4·wr_ptr, then ADDR_BASE+2, then ADDR_BASE−4 → `instr_readdata`=0 for each and `addr_err`=1 sticky. A following accepted `start` clears `addr_err`.
- Assert reset low mid-RUN → same-cycle `cpu_reset`=1, `busy`=0, all flags 0. After release, `start` with empty buffer is ignored.
